// File: rtl/simon_keyexpansion_seq.sv
// Serial SIMON key-schedule engine: loads an M-word master key and
// produces one round key per clock into a registered T-entry array.
module simon_keyexpansion_seq #(
    parameter int          N  = 16,
    parameter int          M  = 4,
    parameter int          T  = 32,
    parameter int          Cb = 5,
    parameter logic [61:0] Z  =
        62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic                  newKey,
    input  logic [M-1:0][N-1:0]   key,
    output logic [T-1:0][N-1:0]   keys,
    output logic                  doneKey
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [Cb-1:0]         cnt_q, cnt_d;
    logic [T-1:0][N-1:0]   keys_q, keys_d;
    logic                  done_q, done_d;

    function automatic logic [N-1:0] ror(input logic [N-1:0] x,
                                         input int r);
        return (x >> r) | (x << (N - r));
    endfunction

    logic [Cb-1:0] idx1, idx3, idxm;
    logic [N-1:0]  k_m1, k_m3, k_mm;
    logic [N-1:0]  tmp0, tmp, knew;
    logic [31:0]   zoff;
    logic [5:0]    zsel;
    logic          zbit;

    assign idx1 = cnt_q - Cb'(1);
    assign idx3 = cnt_q - Cb'(3);
    assign idxm = cnt_q - Cb'(M);
    assign k_m1 = keys_q[idx1];
    assign k_mm = keys_q[idxm];

    // Only the four-word schedule folds in the word three back.
    if (M == 4) begin : g_m4
        assign k_m3 = keys_q[idx3];
    end else begin : g_mx
        assign k_m3 = '0;
    end

    assign zoff = (32'(cnt_q) - 32'(M)) % 32'd62;
    assign zsel = 6'(32'd61 - zoff);
    assign zbit = Z[zsel];

    assign tmp0 = ror(k_m1, 3) ^ k_m3;
    assign tmp  = tmp0 ^ ror(tmp0, 1);
    assign knew = ~k_mm ^ tmp ^ {{(N-1){1'b0}}, zbit} ^ N'(3);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        keys_d  = keys_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (newKey) begin
                    for (int j = 0; j < M; j++) begin
                        keys_d[j] = key[j];
                    end
                    cnt_d   = Cb'(M);
                    done_d  = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                keys_d[cnt_q] = knew;
                if (cnt_q == Cb'(T - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + Cb'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            keys_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            keys_q  <= keys_d;
            done_q  <= done_d;
        end
    end

    assign keys    = keys_q;
    assign doneKey = done_q;

endmodule

// File: tb/tb_simon_keyexpansion_seq.sv
// Directed bench for simon_keyexpansion_seq with a timeline model
// of key visibility and SIMON32/64 cipher vectors.
module tb_simon_keyexpansion_seq;

    localparam int N = 16;
    localparam int M = 4;
    localparam int T = 32;
    localparam logic [61:0] ZS =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    logic                clk = 1'b0;
    logic                nR;
    logic                newKey;
    logic [M-1:0][N-1:0] key;
    logic [T-1:0][N-1:0] keys;
    logic                doneKey;

    simon_keyexpansion_seq dut (
        .clk    (clk),
        .nR     (nR),
        .newKey (newKey),
        .key    (key),
        .keys   (keys),
        .doneKey(doneKey)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [T-1:0][N-1:0] m_cur;
    logic [T-1:0][N-1:0] m_vis;
    logic [T-1:0][N-1:0] gold;
    bit                  m_busy;
    bit                  m_done;
    int                  m_n;

    function automatic logic [15:0] rr(input logic [15:0] x, input int r);
        return (x >> r) | (x << (16 - r));
    endfunction

    function automatic logic [15:0] rl(input logic [15:0] x, input int r);
        return (x << r) | (x >> (16 - r));
    endfunction

    task automatic gen(input logic [M-1:0][N-1:0] k,
                       output logic [T-1:0][N-1:0] o);
        logic [15:0] t;
        o = '0;
        for (int i = 0; i < M; i++) o[i] = k[i];
        for (int i = M; i < T; i++) begin
            t = rr(o[i-1], 3) ^ o[i-3];
            t = t ^ rr(t, 1);
            o[i] = ~o[i-M] ^ t ^ 16'(ZS[61-((i-M)%62)]) ^ 16'd3;
        end
    endtask

    function automatic logic [15:0] fr(input logic [15:0] x);
        return (rl(x, 1) & rl(x, 8)) ^ rl(x, 2);
    endfunction

    function automatic logic [31:0] enc(input logic [T-1:0][N-1:0] k,
                                        input logic [31:0] p);
        logic [15:0] x, y, t;
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < T; i++) begin
            t = x;
            x = y ^ fr(x) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] dec(input logic [T-1:0][N-1:0] k,
                                        input logic [31:0] c);
        logic [15:0] x, y, t;
        x = c[31:16];
        y = c[15:0];
        for (int i = T - 1; i >= 0; i--) begin
            t = y;
            y = x ^ fr(y) ^ k[i];
            x = t;
        end
        return {x, y};
    endfunction

    // Timeline model: entry M+n-1 becomes visible n edges after accept.
    always @(posedge clk or negedge nR) begin
        if (!nR) begin
            m_vis  = '0;
            m_done = 1'b0;
            m_busy = 1'b0;
            m_n    = 0;
        end else if (m_busy) begin
            m_n = m_n + 1;
            m_vis[M+m_n-1] = m_cur[M+m_n-1];
            if (m_n == T - M) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (newKey) begin
            gen(key, m_cur);
            for (int j = 0; j < M; j++) m_vis[j] = m_cur[j];
            m_busy = 1'b1;
            m_n    = 0;
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_assert++;
            if (doneKey !== m_done) begin
                n_fail++;
                $display("FAIL cyc_doneKey t=%0t got %b want %b",
                         $time, doneKey, m_done);
            end
            n_assert++;
            if (keys !== m_vis) begin
                n_fail++;
                for (int i = 0; i < T; i++) begin
                    if (keys[i] !== m_vis[i]) begin
                        $display("FAIL cyc_keys t=%0t idx %0d got %h want %h",
                                 $time, i, keys[i], m_vis[i]);
                        break;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [M-1:0][N-1:0] k);
        @(negedge clk);
        key    = k;
        newKey = 1'b1;
        @(negedge clk);
        newKey = 1'b0;
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (!doneKey && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [M-1:0][N-1:0] k1, k2, k0;
    int                  n;

    initial begin
        k1 = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
        k2 = {16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678};
        k0 = '0;
        nR = 1'b1;
        newKey = 1'b0;
        key = '0;
        #2 nR = 1'b0;
        #1;
        chk("reset_done", 32'(doneKey), 32'd0);
        chk("reset_keys_zero", 32'(keys != '0), 32'd0);
        @(negedge clk);
        nR = 1'b1;
        chk_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_done", 32'(doneKey), 32'd0);
        chk("idle_keys_zero", 32'(keys != '0), 32'd0);

        gen(k1, gold);
        chk("model_k4", 32'(gold[4]), 32'h71C3);
        chk("model_k5", 32'(gold[5]), 32'hB649);

        pulse(k1);
        wait_done(0, n);
        chk("k1_latency", n, 28);
        chk("k1_keys0", 32'(keys[0]), 32'h0100);
        chk("k1_keys1", 32'(keys[1]), 32'h0908);
        chk("k1_keys2", 32'(keys[2]), 32'h1110);
        chk("k1_keys3", 32'(keys[3]), 32'h1918);
        chk("k1_keys4", 32'(keys[4]), 32'h71C3);
        chk("k1_keys5", 32'(keys[5]), 32'hB649);
        chk("encrypt", enc(keys, 32'h65656877), 32'hC69BE9BB);
        chk("decrypt", dec(keys, 32'hC69BE9BB), 32'h65656877);

        pulse(k1);
        n = 0;
        repeat (9) begin
            @(negedge clk);
            n++;
        end
        key    = k2;
        newKey = 1'b1;
        @(negedge clk);
        n++;
        newKey = 1'b0;
        wait_done(n, n);
        chk("ignore_latency", n, 28);
        chk("ignore_keys4", 32'(keys[4]), 32'h71C3);
        chk("ignore_keys31", 32'(keys[31]), 32'(gold[31]));

        pulse(k0);
        chk("rekey_drop", 32'(doneKey), 32'd0);
        wait_done(0, n);
        chk("zero_latency", n, 28);
        chk("zero_keys4", 32'(keys[4]), 32'hFFFD);
        chk("zero_keys5", 32'(keys[5]), 32'h9FFD);

        pulse(k2);
        repeat (14) @(negedge clk);
        #3 nR = 1'b0;
        #1;
        chk("abort_done", 32'(doneKey), 32'd0);
        chk("abort_keys_zero", 32'(keys != '0), 32'd0);
        @(negedge clk);
        nR = 1'b1;
        pulse(k2);
        wait_done(0, n);
        chk("reload_latency", n, 28);
        gen(k2, gold);
        chk("reload_keys0", 32'(keys[0]), 32'h5678);
        chk("reload_keys31", 32'(keys[31]), 32'(gold[31]));
        repeat (3) @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_keyexpansion_seq.md
# simon_keyexpansion_seq

Iterative SIMON key-schedule engine that sits directly upstream of the round controller. It accepts an M-word master key and computes one round key per clock into a registered T-entry round-key array. It raises `doneKey` once all T keys are valid; the controller gates new data on that flag and indexes the array by round number in both directions. It replaces the combinational key expansion with a small, serial, area-oriented engine.

## Interface
- `N`, 16: word size in bits.
- `M`, 4: key words; legal values 2, 3, 4.
- `T`, 32: rounds, which is also the number of round keys.
- `Cb`, 5: round-counter width; must satisfy 2^Cb ≥ T.
- `Z`, 62'b11111010001001010110000111001101111101000100101011000011100110: z-sequence (z0). Term j is `Z[61-j]`.
- `clk`  in  1: system clock; everything is rising-edge.
- `nR`  in  1: asynchronous active-low reset.
- `newKey`  in  1: request to load and expand `key`.
- `key`  in  [M-1:0][N-1:0]: master key; `key[i]` = k_i.
- `keys`  out  [T-1:0][N-1:0]: registered round-key array; `keys[i]` = k_i.
- `doneKey`  out  1: high means `keys` is complete and stable.

## Operation
- States: IDLE, EXPAND, DONE.
- Reset (async, `nR`=0):
  - state = IDLE, counter = 0.
  - `doneKey` = 0, all `keys` entries = 0.
- Accept: `newKey`=1 sampled in IDLE or DONE causes the following on the same edge:
  - `keys[0..M-1]` <= `key[0..M-1]`.
  - counter <= M.
  - `doneKey` <= 0.
  - state <= EXPAND.
- EXPAND, each cycle, with i = counter:
  - tmp = ROR3(k[i-1]).
  - If M==4: tmp ^= k[i-3].
  - tmp ^= ROR1(tmp).
  - k[i] = ~k[i-M] ^ tmp ^ Z[61-((i-M) mod 62)] ^ 3. The z bit is XORed into bit 0 only; the constant 3 is N-bit.
  - The new k[i] is written into `keys[i]`, and the counter increments.
- All arithmetic is N-bit XOR/rotate. No carries.
- When i == T-1 is written: state <= DONE, `doneKey` <= 1, and the counter holds.
- `newKey` during EXPAND is ignored. It is not queued, and the expansion in progress completes.
- DONE holds `keys` and `doneKey` indefinitely.
- A re-key from DONE drops `doneKey` on the accept edge. The system guarantees that a re-key is issued only while the downstream controller is idle. This block does not protect rounds that are in flight.
- Reset mid-EXPAND aborts the expansion. All outputs go to their reset values immediately, with no clock required.
- Entries `keys[M..T-1]` are rewritten every expansion. Stale values from the previous key remain visible while `doneKey`=0, and consumers must ignore them.

## Timing
- Let E0 be the accept edge. Then:
  - `keys[0..M-1]` are valid after E0.
  - `keys[i]` is valid after edge E0+(i-M+1).
  - `doneKey` rises after edge E0+(T-M). For 32/64 this is 28 cycles.
- `doneKey` falls after the accept edge.
- Single write port: exactly one `keys` entry is written per EXPAND cycle.
- The datapath critical path is 3-input indexed reads + 2 rotates + XORs. It is registered into the array, with no output combinational path.
- `newKey` is level-sampled. If it is held high, the block re-expands on every DONE cycle, and `doneKey` pulses for one cycle between runs.

## Test plan
- Reset with `nR`=0 mid-run → `doneKey`=0, all `keys`=0, with no clock edge needed. Release, then idle 10 cycles → outputs unchanged.
- Key {0x1918,0x1110,0x0908,0x0100} (k3..k0), pulse `newKey` →
  - `keys[0..3]`=0x0100,0x0908,0x1110,0x1918; `keys[4]`=0x71C3; `keys[5]`=0xB649.
  - `doneKey`=1 exactly 28 edges after accept.
  - Remaining entries match the golden model.
- Same key, then drive the downstream controller with `enc_dec`=1, plaintext 0x65656877 → cipher 0xC69BE9BB. Decrypt 0xC69BE9BB → 0x65656877.
- Pulse `newKey` with a different key at cycle 10 of EXPAND → ignored. The final `keys` match the first key, and `doneKey` timing is unchanged.
- From DONE, pulse `newKey` with key all-zeros → `doneKey` is 0 on the next cycle and 1 after 28 edges. `keys` match the golden model for the zero key.
- Assert `nR` at cycle 15 of EXPAND, then reload → a full 28-cycle expansion with correct keys and no residue from the aborted run.
